basic_soc_trap_csr: RTL and testbench

- Machine-mode CSR file and trap/return unit of the basic_soc RV32 core.
- Serves CSR instructions (CSRRW/S/C and immediate forms) from the execute stage and flags illegal CSR accesses.
- Latches trap state (mepc, mcause, mtval) on exceptions and supplies the trap vector (mtvec) and MRET return address (mepc) to the fetch redirect logic.

---
 rtl/basic_soc_trap_csr_pkg.sv | 39 +++
 rtl/trap_causes_pkg.sv | 9 +
 rtl/basic_soc_trap_csr.sv | 128 ++++++++++++
 tb/tb_basic_soc_trap_csr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/basic_soc_trap_csr_pkg.sv
// Shared CSR addresses, CSR operation encoding and address decode helper.
package basic_soc_trap_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // RV32I only: MXL=1 in the top bits, extension bit 8 (I)
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // csr_op carries funct3[1:0] of the CSR instruction
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // True for every address this CSR file answers to
    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MVENDORID,
            CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: csr_implemented = 1'b1;
            default:                               csr_implemented = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trap_causes_pkg.sv
// Exception cause codes written into mcause by the basic_soc core.
package trap_causes;

    localparam logic [31:0] EXC_INSTR_MISALIGNED = 32'd0;
    localparam logic [31:0] EXC_ILLEGAL_INSTR    = 32'd2;
    localparam logic [31:0] EXC_BREAKPOINT       = 32'd3;
    localparam logic [31:0] EXC_ECALL_M          = 32'd11;

endpackage

// File: rtl/basic_soc_trap_csr.sv
// Machine-mode CSR file plus trap entry / MRET state handling for the
// basic_soc RV32 core. Reads are combinational (pre-write value); all state
// updates happen in one clocked block with priority reset > trap > mret > write.
module basic_soc_trap_csr
    import basic_soc_trap_csr_pkg::*;
#(
    parameter int               XLEN    = 32,
    parameter logic [XLEN-1:0]  HART_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    output logic [XLEN-1:0] trap_target,
    input  logic            mret_valid,
    output logic [XLEN-1:0] mret_target
);

    logic            mstatus_mie_reg;
    logic            mstatus_mpie_reg;
    logic [XLEN-1:0] mie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mscratch_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mtval_reg;

    logic [XLEN-1:0] mstatus_view;
    logic [XLEN-1:0] csr_wdata_next;
    logic            write_attempt;
    logic            write_en;

    // Low two bits of mtvec/mepc are hardwired zero (direct mode, aligned PC)
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    // Assemble the visible mstatus: MPP fixed at M-mode, only MIE/MPIE live
    always_comb begin
        mstatus_view        = '0;
        mstatus_view[12:11] = 2'b11;
        mstatus_view[7]     = mstatus_mpie_reg;
        mstatus_view[3]     = mstatus_mie_reg;
    end

    // Read mux, legality check and read-modify-write value
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_view;
            CSR_MISA:     csr_rdata = XLEN'(MISA_VALUE);
            CSR_MIE:      csr_rdata = mie_reg;
            CSR_MTVEC:    csr_rdata = mtvec_reg;
            CSR_MSCRATCH: csr_rdata = mscratch_reg;
            CSR_MEPC:     csr_rdata = mepc_reg;
            CSR_MCAUSE:   csr_rdata = mcause_reg;
            CSR_MTVAL:    csr_rdata = mtval_reg;
            CSR_MHARTID:  csr_rdata = HART_ID;
            default:      csr_rdata = '0;
        endcase

        // RS/RC with rs1=x0 / zimm=0 are pure reads and may target RO CSRs
        write_attempt = (csr_op == CSR_OP_RW) ||
                        (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && !csr_src_zero);

        csr_illegal = csr_valid &&
                      (!csr_implemented(csr_addr) ||
                       ((csr_addr[11:10] == 2'b11) && write_attempt));

        write_en = csr_valid && write_attempt && !csr_illegal;

        case (csr_op)
            CSR_OP_RW: csr_wdata_next = csr_wdata;
            CSR_OP_RS: csr_wdata_next = csr_rdata | csr_wdata;
            CSR_OP_RC: csr_wdata_next = csr_rdata & ~csr_wdata;
            default:   csr_wdata_next = csr_rdata;
        endcase
    end

    assign trap_target = mtvec_reg & ALIGN_MASK;
    assign mret_target = mepc_reg;

    // State update: reset beats trap, trap beats mret, mret beats CSR write
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= '0;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else if (trap_valid) begin
            // Faulting instruction never commits, so its CSR write is dropped
            mepc_reg         <= trap_pc & ALIGN_MASK;
            mcause_reg       <= trap_cause;
            mtval_reg        <= trap_tval;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (write_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_reg  <= csr_wdata_next[3];
                    mstatus_mpie_reg <= csr_wdata_next[7];
                end
                CSR_MIE:      mie_reg      <= csr_wdata_next;
                CSR_MTVEC:    mtvec_reg    <= csr_wdata_next & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_reg <= csr_wdata_next;
                CSR_MEPC:     mepc_reg     <= csr_wdata_next & ALIGN_MASK;
                CSR_MCAUSE:   mcause_reg   <= csr_wdata_next;
                CSR_MTVAL:    mtval_reg    <= csr_wdata_next;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_soc_trap_csr.sv
// Directed-vector bench for basic_soc_trap_csr with hand-computed expectations.
module tb_basic_soc_trap_csr;
    import basic_soc_trap_csr_pkg::*;
    import trap_causes::*;

    logic        clk;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic [31:0] trap_target;
    logic        mret_valid;
    logic [31:0] mret_target;

    int checks;
    int failures;

    basic_soc_trap_csr #(.XLEN(32), .HART_ID(32'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_valid    (csr_valid),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_src_zero (csr_src_zero),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .trap_target  (trap_target),
        .mret_valid   (mret_valid),
        .mret_target  (mret_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance one edge; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CSR instruction: check combinational outputs, then commit at the edge
    task automatic csr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic zero,
                       input logic [31:0] exp_rd, input logic exp_ill);
        csr_valid    = 1'b1;
        csr_op       = op;
        csr_addr     = addr;
        csr_wdata    = wd;
        csr_src_zero = zero;
        #2;
        if (!exp_ill) check({tag, ".rdata"}, csr_rdata, exp_rd);
        check({tag, ".illegal"}, {31'd0, csr_illegal}, {31'd0, exp_ill});
        tick();
        csr_valid    = 1'b0;
        csr_op       = 2'b00;
        csr_wdata    = '0;
        csr_src_zero = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr(tag, CSR_OP_RS, addr, 32'd0, 1'b1, exp, 1'b0);
    endtask

    task automatic set_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        trap_valid = 1'b1;
        trap_cause = cause;
        trap_pc    = pc;
        trap_tval  = tval;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        csr_valid    = 1'b0;
        csr_op       = 2'b00;
        csr_addr     = '0;
        csr_wdata    = '0;
        csr_src_zero = 1'b0;
        trap_valid   = 1'b0;
        trap_cause   = '0;
        trap_pc      = '0;
        trap_tval    = '0;
        mret_valid   = 1'b0;

        repeat (2) tick();
        check("reset.trap_target", trap_target, 32'h0);
        check("reset.mret_target", mret_target, 32'h0);
        rst = 1'b1;

        rd("mstatus.reset", CSR_MSTATUS, 32'h0000_1800);
        rd("misa", CSR_MISA, 32'h4000_0100);
        rd("mhartid", CSR_MHARTID, 32'h0);

        // mtvec: written mode bits read back as zero
        csr("mtvec.rw0e", CSR_OP_RW, CSR_MTVEC, 32'h0E, 1'b0, 32'h0, 1'b0);
        check("trap_target.0c", trap_target, 32'h0C);
        rd("mtvec.0c", CSR_MTVEC, 32'h0C);
        csr("mtvec.rw1f", CSR_OP_RW, CSR_MTVEC, 32'h1F, 1'b0, 32'h0C, 1'b0);
        check("trap_target.1c", trap_target, 32'h1C);

        // Enable MIE, then take an illegal-instruction trap
        csr("mstatus.mie", CSR_OP_RW, CSR_MSTATUS, 32'h8, 1'b0, 32'h1800, 1'b0);
        set_trap(EXC_ILLEGAL_INSTR, 32'h14, 32'hF11F_D073);
        #2;
        check("trap1.target", trap_target, 32'h1C);
        tick();
        trap_valid = 1'b0;
        rd("trap1.mepc", CSR_MEPC, 32'h14);
        rd("trap1.mcause", CSR_MCAUSE, 32'h2);
        rd("trap1.mtval", CSR_MTVAL, 32'hF11F_D073);
        rd("trap1.mstatus", CSR_MSTATUS, 32'h0000_1880);
        check("trap1.mret_target", mret_target, 32'h14);

        // Read-only region: writes are illegal, pure reads are legal
        csr("mhartid.rw", CSR_OP_RW, CSR_MHARTID, 32'h1F, 1'b0, 32'h0, 1'b1);
        csr("mvendorid.rs", CSR_OP_RS, CSR_MVENDORID, 32'h1, 1'b0, 32'h0, 1'b1);
        csr("mvendorid.rs0", CSR_OP_RS, CSR_MVENDORID, 32'h0, 1'b1, 32'h0, 1'b0);
        csr("marchid.rc", CSR_OP_RC, CSR_MARCHID, 32'h4, 1'b0, 32'h0, 1'b1);
        rd("mepc.after_illegal", CSR_MEPC, 32'h14);

        // mepc rewrite then MRET restores MIE from MPIE
        csr("mepc.rw3c", CSR_OP_RW, CSR_MEPC, 32'h3C, 1'b0, 32'h14, 1'b0);
        mret_valid = 1'b1;
        #2;
        check("mret.target", mret_target, 32'h3C);
        tick();
        mret_valid = 1'b0;
        rd("mret.mstatus", CSR_MSTATUS, 32'h0000_1888);

        // RS/RC read-modify-write on mie
        csr("mie.rs", CSR_OP_RS, CSR_MIE, 32'h888, 1'b0, 32'h0, 1'b0);
        csr("mie.rc", CSR_OP_RC, CSR_MIE, 32'h800, 1'b0, 32'h888, 1'b0);
        rd("mie.final", CSR_MIE, 32'h088);

        // Trap in the same cycle as a CSR write: write is dropped
        csr("mscratch.rw", CSR_OP_RW, CSR_MSCRATCH, 32'hA5A5, 1'b0, 32'h0, 1'b0);
        set_trap(EXC_BREAKPOINT, 32'h23, 32'h99);
        csr("trap2.mscratch_wr", CSR_OP_RW, CSR_MSCRATCH, 32'h1234, 1'b0, 32'hA5A5, 1'b0);
        trap_valid = 1'b0;
        rd("trap2.mscratch", CSR_MSCRATCH, 32'hA5A5);
        rd("trap2.mepc", CSR_MEPC, 32'h20);
        rd("trap2.mcause", CSR_MCAUSE, 32'h3);
        rd("trap2.mtval", CSR_MTVAL, 32'h99);
        rd("trap2.mstatus", CSR_MSTATUS, 32'h0000_1880);

        // Trap and MRET together: trap wins
        set_trap(EXC_ECALL_M, 32'h40, 32'h0);
        mret_valid = 1'b1;
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        rd("trap_vs_mret.mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd("trap_vs_mret.mcause", CSR_MCAUSE, 32'd11);

        // Alignment, unimplemented address, mip, mstatus masking
        csr("mepc.rw3e", CSR_OP_RW, CSR_MEPC, 32'h3E, 1'b0, 32'h40, 1'b0);
        rd("mepc.3c", CSR_MEPC, 32'h3C);
        csr("unimpl.7c0", CSR_OP_RS, 12'h7C0, 32'h0, 1'b1, 32'h0, 1'b1);
        csr("mip.rw", CSR_OP_RW, CSR_MIP, 32'hFFF, 1'b0, 32'h0, 1'b0);
        rd("mip.read", CSR_MIP, 32'h0);
        csr("mstatus.all1", CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF, 1'b0, 32'h1800, 1'b0);
        rd("mstatus.mask", CSR_MSTATUS, 32'h0000_1888);

        // Reset mid-operation overrides a concurrent trap
        set_trap(EXC_INSTR_MISALIGNED, 32'h80, 32'h81);
        rst = 1'b0;
        tick();
        trap_valid = 1'b0;
        rst = 1'b1;
        check("rst2.trap_target", trap_target, 32'h0);
        check("rst2.mret_target", mret_target, 32'h0);
        rd("rst2.mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd("rst2.mscratch", CSR_MSCRATCH, 32'h0);
        rd("rst2.mie", CSR_MIE, 32'h0);
        rd("rst2.mcause", CSR_MCAUSE, 32'h0);
        rd("rst2.mtval", CSR_MTVAL, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
